mat_sram_responder: RTL
=======================

MAT_SRAM_RESPONDER -- requirements
Module: mat_sram_responder

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, meaning bits per matrix element.
REQ-002 SHALL have parameter N, default 8, meaning elements per row; row width W = DATA_LEN*N.
REQ-003 SHALL have parameter ADDRESS_SIZE, default 4, meaning row address width; depth D = 2**ADDRESS_SIZE.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock.
REQ-005 SHALL have port i_rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have wide-port inputs, driven by the matrix controller:
- i_address  ADDRESS_SIZE
- i_chipselect  1
- i_clken  1
- i_write  1
- i_writedata  W
- i_byteenable  W/8
REQ-007 SHALL have port o_readdata, output, W, meaning wide-port read data.
REQ-008 SHALL have host-port inputs: i_h_address (ADDRESS_SIZE+clog2(N)), i_h_read (1), i_h_write (1), i_h_writedata (DATA_LEN).
REQ-009 SHALL have host-port outputs: o_h_readdata (DATA_LEN), o_h_readdatavalid (1), o_h_waitrequest (1).
REQ-010 SHALL have port i_clear (input, 1) and port o_clear_busy (output, 1) only when MAT_SRAM_CLEAR_EN is defined.

Function
REQ-011 SHALL store D rows of W bits; host word index = i_h_address low clog2(N) bits, row = high ADDRESS_SIZE bits; word k occupies row bits [k*DATA_LEN +: DATA_LEN].
REQ-012 Wide access is active when i_chipselect and i_clken are both 1; with i_clken=0, no write occurs and o_readdata holds its value.
REQ-013 Wide read (active, i_write=0): o_readdata SHALL equal mem[i_address] after the next rising edge (1-cycle latency), then hold until the next wide read.
REQ-014 Wide write (active, i_write=1): each byte with its i_byteenable bit set SHALL be written on that edge, other bytes unchanged, and o_readdata SHALL hold its value.
REQ-015 A wide read in the cycle after a wide write to the same row SHALL return the newly written data.
REQ-016 Host port SHALL follow a waitrequest handshake: a request is accepted on an edge where i_h_read or i_h_write is 1 and o_h_waitrequest=0.
REQ-017 o_h_waitrequest SHALL be 1 combinationally whenever a wide access is active, or (when MAT_SRAM_CLEAR_EN is defined) o_clear_busy=1; otherwise it is 0.
REQ-018 The wide port always wins arbitration; the host port never stalls or corrupts a wide access.
REQ-019 Accepted host write SHALL update only the addressed DATA_LEN word.
REQ-020 Accepted host read: o_h_readdata SHALL be loaded and o_h_readdatavalid SHALL pulse for exactly one cycle, one cycle after acceptance.
REQ-021 Host read FSM: IDLE -> RESP on an accepted read; RESP -> RESP on another accepted read; otherwise RESP -> IDLE. Back-to-back reads give one valid pulse per read.
REQ-022 i_h_read and i_h_write both 1 SHALL be treated as a write only.
REQ-023 o_h_readdata SHALL hold its value between valid pulses.

Reset
REQ-024 While i_rst=1, asynchronously: o_readdata=0, o_h_readdata=0, o_h_readdatavalid=0, host FSM=IDLE, o_clear_busy=0, clear row counter=0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 A read pending when reset asserts SHALL be dropped, with no valid pulse after release.
REQ-027 An access presented in the same cycle as reset SHALL have no effect.

Configuration
REQ-028 Macro MAT_SRAM_CLEAR_EN SHALL select the clear feature.
REQ-029 With the macro defined, a 1-cycle pulse on i_clear while idle SHALL set o_clear_busy=1 and write zero to rows 0..D-1, one row per cycle, in ascending order.
- The walker pauses in any cycle with an active wide access and resumes at the same row.
- o_clear_busy drops the cycle after row D-1 is cleared.
- i_clear while busy SHALL be ignored.
REQ-030 Without the macro, i_clear and o_clear_busy are absent, there is no clear logic, and o_h_waitrequest depends only on wide activity.

Verification
REQ-031 Wide write row 3 = 0x0123...EF (all bytes enabled), wide read row 3 next cycle -> o_readdata = written value one edge later.
REQ-032 Row 5 holds all 0xFF; wide write 0 with i_byteenable=0x0000000F -> row 5 low 32 bits = 0, rest remain 0xFF.
REQ-033 Host write 0xDEADBEEF to i_h_address=0x2A (row 5, word 2) during an active wide read -> waitrequest=1 that cycle; accepted the next idle cycle; wide read of row 5 shows bits [95:64]=0xDEADBEEF.
REQ-034 Three back-to-back host reads of words 0,1,2 with no wide traffic -> three consecutive valid pulses with the matching data.
REQ-035 Host read accepted, i_rst asserted the next cycle -> no valid pulse; o_h_readdata=0.
REQ-036 (MAT_SRAM_CLEAR_EN) i_clear pulse, with one wide read injected at cycle 4 -> o_clear_busy high for D+1 cycles; all rows read back 0.

Source files
------------

// File: rtl/mat_sram_responder.sv
// Dual-ported matrix row SRAM: wide row port for the matrix controller (always wins) plus a
// word-wide host port with waitrequest handshake. Define MAT_SRAM_CLEAR_EN for the row-clear walker.
module mat_sram_responder #(
  parameter int DATA_LEN     = 32,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
`ifdef MAT_SRAM_CLEAR_EN
  input  logic                                i_clear,
  output logic                                o_clear_busy,
`endif
  input  logic [ADDRESS_SIZE-1:0]             i_address,
  input  logic                                i_chipselect,
  input  logic                                i_clken,
  input  logic                                i_write,
  input  logic [DATA_LEN*N-1:0]               i_writedata,
  input  logic [(DATA_LEN*N)/8-1:0]           i_byteenable,
  output logic [DATA_LEN*N-1:0]               o_readdata,
  input  logic [ADDRESS_SIZE+$clog2(N)-1:0]   i_h_address,
  input  logic                                i_h_read,
  input  logic                                i_h_write,
  input  logic [DATA_LEN-1:0]                 i_h_writedata,
  output logic [DATA_LEN-1:0]                 o_h_readdata,
  output logic                                o_h_readdatavalid,
  output logic                                o_h_waitrequest
);
  localparam int W    = DATA_LEN * N;
  localparam int D    = 2 ** ADDRESS_SIZE;
  localparam int WIDX = $clog2(N);
  localparam int BEW  = W / 8;
  localparam int SW   = $clog2(W) + 1;

  typedef enum logic {IDLE, RESP} state_t;

  logic [W-1:0]              mem_q [D];
  logic [W-1:0]              rdata_q;
  logic [DATA_LEN-1:0]       hrdata_q;
  state_t                    state_q, state_d;

  logic                      wide_act, h_busy, h_acc, h_wr_acc, h_rd_acc;
  logic [ADDRESS_SIZE-1:0]   h_row;
  logic [WIDX-1:0]           h_word;
  logic [SW-1:0]             h_sh;
  logic [W-1:0]              be_mask;
  logic                      mem_we;
  logic [ADDRESS_SIZE-1:0]   mem_waddr;
  logic [W-1:0]              mem_wmask, mem_wdata;

  assign wide_act = i_chipselect & i_clken;

`ifdef MAT_SRAM_CLEAR_EN
  logic                      clr_busy_q;
  logic [ADDRESS_SIZE-1:0]   clr_row_q;
  logic                      clr_we;

  // The walker yields to any wide access and retries the same row next cycle.
  assign clr_we       = clr_busy_q & ~wide_act;
  assign o_clear_busy = clr_busy_q;
  assign h_busy       = wide_act | clr_busy_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_busy_q <= 1'b0;
      clr_row_q  <= '0;
    end else if (clr_busy_q) begin
      if (clr_we) begin
        clr_row_q <= clr_row_q + 1'b1;
        if (&clr_row_q) clr_busy_q <= 1'b0;
      end
    end else if (i_clear) begin
      clr_busy_q <= 1'b1;
      clr_row_q  <= '0;
    end
  end
`else
  assign h_busy = wide_act;
`endif

  assign o_h_waitrequest = h_busy;
  assign h_acc    = (i_h_read | i_h_write) & ~h_busy;
  assign h_wr_acc = h_acc & i_h_write;
  assign h_rd_acc = h_acc & ~i_h_write;
  assign h_row    = i_h_address[WIDX +: ADDRESS_SIZE];
  assign h_word   = i_h_address[WIDX-1:0];
  assign h_sh     = SW'(h_word) * SW'(DATA_LEN);

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BEW; b++) be_mask[b*8 +: 8] = {8{i_byteenable[b]}};
  end

  // Single merged write port; sources are mutually exclusive by arbitration.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_address;
    mem_wmask = '0;
    mem_wdata = '0;
    if (!i_rst) begin
      if (wide_act && i_write) begin
        mem_we    = 1'b1;
        mem_wmask = be_mask;
        mem_wdata = i_writedata;
      end else if (h_wr_acc) begin
        mem_we    = 1'b1;
        mem_waddr = h_row;
        mem_wmask = W'({DATA_LEN{1'b1}}) << h_sh;
        mem_wdata = W'(i_h_writedata) << h_sh;
      end
`ifdef MAT_SRAM_CLEAR_EN
      else if (clr_we) begin
        mem_we    = 1'b1;
        mem_waddr = clr_row_q;
        mem_wmask = '1;
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q  <= '0;
      hrdata_q <= '0;
    end else begin
      if (wide_act && !i_write) rdata_q <= mem_q[i_address];
      if (h_rd_acc) hrdata_q <= DATA_LEN'(mem_q[h_row] >> h_sh);
    end
  end

  assign o_readdata   = rdata_q;
  assign o_h_readdata = hrdata_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (h_rd_acc) state_d = RESP;
      RESP:    if (h_rd_acc) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_h_readdatavalid = (state_q == RESP);
  end
endmodule
